serial_sub_cmp: RTL and testbench

- Multi-cycle subtractor that computes A-B one SLICE-bit chunk per clock, LSB chunk first, with a carry held between cycles.
- Produces the WIDTH-bit difference and the eq/less/upper flag triple the ALU compare path expects.
- Sits upstream of the branch/compare flag logic: the sequential producer of the difference word that feeds compare decisions, for area-constrained or multi-cycle ALU configurations.

---
 rtl/serial_sub_cmp_if.sv | 25 ++
 rtl/serial_sub_cmp.sv | 109 ++++++++++
 tb/tb_serial_sub_cmp.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/serial_sub_cmp_if.sv
// Operand/result bundle for serial_sub_cmp.
// The master drives start/a/b; the slave returns the status, difference and flags.
interface serial_sub_cmp_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             eq;
    logic             less;
    logic             upper;

    modport master (
        output start, a, b,
        input  busy, done, diff, eq, less, upper
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, eq, less, upper
    );
endinterface

// File: rtl/serial_sub_cmp.sv
// Serial subtractor: a-b one SLICE-bit chunk per clock, LSB first, with eq/less/upper flags.
// Define SERIAL_SUB_OVF_CORRECT_EN to correct the flags for signed overflow.
module serial_sub_cmp #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input logic             clk,
    input logic             rst_n,
    serial_sub_cmp_if.slave bus
);
    localparam int unsigned NSlices = WIDTH / SLICE;
    localparam int unsigned CntW    = (NSlices > 1) ? $clog2(NSlices) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bInv;
    logic             carry;
    logic [CntW-1:0]  cnt;

    logic [SLICE-1:0] aSlice;
    logic [SLICE-1:0] bSlice;
    logic [SLICE:0]   sum;
    logic [WIDTH-1:0] diffNext;
    logic             lastSlice;
    logic             tz;
    logic             sgn;
    logic             eqNext;
    logic             lessNext;
    logic             upperNext;
`ifdef SERIAL_SUB_OVF_CORRECT_EN
    logic             ovf;
`endif

    always_comb begin
        aSlice    = aReg[cnt*SLICE +: SLICE];
        bSlice    = bInv[cnt*SLICE +: SLICE];
        sum       = {1'b0, aSlice} + {1'b0, bSlice} + {{SLICE{1'b0}}, carry};
        diffNext  = bus.diff;
        diffNext[cnt*SLICE +: SLICE] = sum[SLICE-1:0];
        lastSlice = (cnt == CntW'(NSlices - 1));
        tz        = |diffNext[WIDTH-2:0];
        sgn       = diffNext[WIDTH-1];
        eqNext    = ~sgn & ~tz;
`ifdef SERIAL_SUB_OVF_CORRECT_EN
        // Carry into the MSB is recovered from the MSB sum bit: cin = a ^ ~b ^ s.
        ovf       = (aSlice[SLICE-1] ^ bSlice[SLICE-1] ^ sum[SLICE-1]) ^ sum[SLICE];
        lessNext  = sgn ^ ovf;
        upperNext = ~eqNext & ~lessNext;
`else
        lessNext  = sgn;
        upperNext = ~sgn & tz;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            aReg      <= '0;
            bInv      <= '0;
            carry     <= 1'b1;
            cnt       <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.diff  <= '0;
            bus.eq    <= 1'b0;
            bus.less  <= 1'b0;
            bus.upper <= 1'b0;
        end else begin
            case (state)
                StIdle, StDone: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        state     <= StRun;
                        aReg      <= bus.a;
                        bInv      <= ~bus.b;
                        carry     <= 1'b1;
                        cnt       <= '0;
                        bus.busy  <= 1'b1;
                        bus.diff  <= '0;
                        bus.eq    <= 1'b0;
                        bus.less  <= 1'b0;
                        bus.upper <= 1'b0;
                    end else begin
                        state    <= StIdle;
                        bus.busy <= 1'b0;
                    end
                end
                StRun: begin
                    bus.diff <= diffNext;
                    carry    <= sum[SLICE];
                    if (lastSlice) begin
                        state     <= StDone;
                        cnt       <= '0;
                        bus.busy  <= 1'b0;
                        bus.done  <= 1'b1;
                        bus.eq    <= eqNext;
                        bus.less  <= lessNext;
                        bus.upper <= upperNext;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub_cmp.sv
// Directed bench for serial_sub_cmp (32-bit operands, 8-bit slices).
module tb_serial_sub_cmp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   lat;
    int   busyCnt;
    int   doneSeen;

    serial_sub_cmp_if #(.WIDTH(32)) bus ();

    serial_sub_cmp #(.WIDTH(32), .SLICE(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Edges until done is seen (bounded); busyCnt counts busy samples before done.
    task automatic waitDone(output int n, output int bc);
        n  = 0;
        bc = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (bus.busy) bc++;
        end while (!bus.done && n < 20);
    endtask

    // Accept one operation, check the cleared outputs, then wait for done.
    task automatic runOp(input logic [31:0] av, input logic [31:0] bv,
                         output int n, output int bc);
        @(negedge clk);
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_at_start", {31'd0, bus.busy}, 32'd1);
        check("diff_cleared", bus.diff, 32'd0);
        waitDone(n, bc);
        bc++;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #12;
        check("rst_busy",  {31'd0, bus.busy},  32'd0);
        check("rst_done",  {31'd0, bus.done},  32'd0);
        check("rst_diff",  bus.diff,           32'd0);
        check("rst_eq",    {31'd0, bus.eq},    32'd0);
        check("rst_less",  {31'd0, bus.less},  32'd0);
        check("rst_upper", {31'd0, bus.upper}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 5 - 5
        runOp(32'd5, 32'd5, lat, busyCnt);
        check("eq_latency", lat, 32'd4);
        check("eq_busy_cycles", busyCnt, 32'd4);
        check("eq_diff", bus.diff, 32'd0);
        check("eq_flags", {29'd0, bus.eq, bus.less, bus.upper}, 32'b100);
        @(posedge clk);
        #1;
        check("done_single_pulse", {31'd0, bus.done}, 32'd0);
        check("hold_diff_idle", bus.diff, 32'd0);
        check("hold_eq_idle", {31'd0, bus.eq}, 32'd1);

        // 3 - 7
        runOp(32'd3, 32'd7, lat, busyCnt);
        check("lt_latency", lat, 32'd4);
        check("lt_diff", bus.diff, 32'hFFFF_FFFC);
        check("lt_flags", {29'd0, bus.eq, bus.less, bus.upper}, 32'b010);

        // Borrow crosses slice boundaries
        runOp(32'h0000_0100, 32'h0000_0001, lat, busyCnt);
        check("carry1_diff", bus.diff, 32'h0000_00FF);
        check("carry1_flags", {29'd0, bus.eq, bus.less, bus.upper}, 32'b001);
        runOp(32'h0001_0000, 32'h0000_0001, lat, busyCnt);
        check("carry2_diff", bus.diff, 32'h0000_FFFF);
        check("carry2_flags", {29'd0, bus.eq, bus.less, bus.upper}, 32'b001);

        // Back-to-back with start held high; operands scrambled mid-RUN
        @(negedge clk);
        bus.a     = 32'd10;
        bus.b     = 32'd2;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.a = 32'd99;
        bus.b = 32'd50;
        waitDone(lat, busyCnt);
        check("b2b0_latency", lat, 32'd4);
        check("b2b0_diff", bus.diff, 32'd8);
        check("b2b0_flags", {29'd0, bus.eq, bus.less, bus.upper}, 32'b001);
        for (int k = 1; k <= 2; k++) begin
            bus.a = 32'd10;
            bus.b = 32'd2;
            @(posedge clk);
            #1;
            bus.a = 32'd99;
            bus.b = 32'd50;
            check("b2b_restart_busy", {31'd0, bus.busy}, 32'd1);
            waitDone(lat, busyCnt);
            check("b2b_period", lat + 1, 32'd5);
            check("b2b_diff", bus.diff, 32'd8);
            check("b2b_flags", {29'd0, bus.eq, bus.less, bus.upper}, 32'b001);
        end
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_stop_busy", {31'd0, bus.busy}, 32'd0);
        check("b2b_stop_done", {31'd0, bus.done}, 32'd0);

        // Reset during the second RUN cycle
        @(negedge clk);
        bus.a     = 32'h1234_5678;
        bus.b     = 32'd1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_diff", bus.diff, 32'd0);
        check("abort_flags", {29'd0, bus.eq, bus.less, bus.upper}, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        doneSeen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) doneSeen++;
        end
        check("abort_no_done", doneSeen, 32'd0);
        runOp(32'd1, 32'd2, lat, busyCnt);
        check("post_abort_latency", lat, 32'd4);
        check("post_abort_diff", bus.diff, 32'hFFFF_FFFF);
        check("post_abort_flags", {29'd0, bus.eq, bus.less, bus.upper}, 32'b010);

        // Signed overflow: +max vs -1
        runOp(32'h7FFF_FFFF, 32'hFFFF_FFFF, lat, busyCnt);
        check("ovf_diff", bus.diff, 32'h8000_0000);
`ifdef SERIAL_SUB_OVF_CORRECT_EN
        check("ovf_flags", {29'd0, bus.eq, bus.less, bus.upper}, 32'b001);
`else
        check("ovf_flags", {29'd0, bus.eq, bus.less, bus.upper}, 32'b010);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
